// File: rtl/sd_frame_read_sched_pkg.sv
// sd_video_pkg: shared constants and the scheduler state type.
//   SLOTn_ADDR_DEF       first SD sector of each of the four clip slots
//   FRAME_SECS_DEF       sectors per raw Bayer frame
//   FRAMES_PER_CLIP_DEF  frames per clip before wrapping to frame 0
//   TIMEOUT_CYC_DEF      per-sector watchdog limit in clk cycles
//   sched_state_t        frame read scheduler FSM states
package sd_video_pkg;

    localparam logic [31:0] SLOT0_ADDR_DEF      = 32'd16640;
    localparam logic [31:0] SLOT1_ADDR_DEF      = 32'd2978816;
    localparam logic [31:0] SLOT2_ADDR_DEF      = 32'd5941248;
    localparam logic [31:0] SLOT3_ADDR_DEF      = 32'd8903680;
    localparam int          FRAME_SECS_DEF      = 8228;
    localparam int          FRAMES_PER_CLIP_DEF = 300;
    localparam int          TIMEOUT_CYC_DEF     = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        NEXT,
        FRAME_WAIT,
        ERROR
    } sched_state_t;

endpackage

// File: rtl/sd_frame_read_sched_if.sv
// sd_frame_read_sched_if: link between the frame scheduler and the SD read controller.
//   rd_start_en  scheduler -> controller, one-cycle sector read start pulse
//   rd_sec_addr  scheduler -> controller, sector address, valid with rd_start_en and held after
//   rd_busy      controller -> scheduler, high while a sector read is in progress
//
// Handshake: rd_start_en is a single-cycle request with rd_sec_addr valid in the
// same cycle; there is no ready signal. The controller acknowledges by raising
// rd_busy and reports completion by dropping it. A new start is only issued
// after the falling edge of rd_busy has been seen.
interface sd_frame_read_sched_if;

    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        rd_busy;

    modport master (output rd_start_en, output rd_sec_addr, input rd_busy);
    modport slave  (input rd_start_en, input rd_sec_addr, output rd_busy);

endinterface

// File: rtl/sd_frame_read_sched_watchdog.sv
// sd_rd_watchdog: rd_busy edge detector plus per-sector timeout counter.
//   clk, rst   clock, synchronous active-high reset
//   busy_in    rd_busy from the SD read controller
//   clear      restart the timer at zero (sector start cycle)
//   run        advance the timer (waiting on the controller)
//   rise/fall  rd_busy edges against its one-cycle delayed copy
//   expired    timer has reached TIMEOUT_CYC-1
module sd_rd_watchdog
    import sd_video_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_in,
    input  logic clear,
    input  logic run,
    output logic rise,
    output logic fall,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic          busy_d;
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_d <= 1'b0;
            timer  <= '0;
        end else begin
            busy_d <= busy_in;
            if (clear) begin
                timer <= '0;
            end else if (run && !expired) begin
                // Saturates at the limit so expired stays asserted.
                timer <= timer + 1'b1;
            end
        end
    end

    assign rise    = busy_in & ~busy_d;
    assign fall    = ~busy_in & busy_d;
    assign expired = (timer == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sd_frame_read_sched.sv
// sd_frame_read_sched: sequences multi-sector SD reads of raw video clips, one
// frame at a time, paced to the display frame tick and gated by FIFO backpressure.
//   clk, rst      clock, synchronous active-high reset
//   enable        run request; a drop takes effect between sectors
//   switch_video  requested clip slot, sampled at start and at frame boundaries
//   frame_tick    one-cycle display frame pulse
//   fifo_afull    DDR write FIFO almost full, holds off new sector starts
//   sd            SD read controller link (rd_start_en / rd_sec_addr / rd_busy)
//   frame_start   pulse when the first sector of a frame is about to be issued
//   frame_done    pulse when the last sector of a frame has completed
//   cur_slot      slot being read; frame_idx  frame index within the clip
//   err_timeout   sticky SD timeout flag, cleared by dropping enable
//   busy          high in every state except IDLE; dbg_state  FSM state
module sd_frame_read_sched
    import sd_video_pkg::*;
#(
    parameter logic [31:0] SLOT0_ADDR      = SLOT0_ADDR_DEF,
    parameter logic [31:0] SLOT1_ADDR      = SLOT1_ADDR_DEF,
    parameter logic [31:0] SLOT2_ADDR      = SLOT2_ADDR_DEF,
    parameter logic [31:0] SLOT3_ADDR      = SLOT3_ADDR_DEF,
    parameter int          FRAME_SECS      = FRAME_SECS_DEF,
    parameter int          FRAMES_PER_CLIP = FRAMES_PER_CLIP_DEF,
    parameter int          TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
    parameter bit          PACE_EN         = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [1:0]                   switch_video,
    input  logic                         frame_tick,
    input  logic                         fifo_afull,
    sd_frame_read_sched_if.master        sd,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic [1:0]                   cur_slot,
    output logic [15:0]                  frame_idx,
    output logic                         err_timeout,
    output logic                         busy,
    output sched_state_t                 dbg_state
);

    localparam int SW = (FRAME_SECS > 1) ? $clog2(FRAME_SECS) : 1;

    function automatic logic [31:0] slot_base(input logic [1:0] s);
        case (s)
            2'd0:    return SLOT0_ADDR;
            2'd1:    return SLOT1_ADDR;
            2'd2:    return SLOT2_ADDR;
            default: return SLOT3_ADDR;
        endcase
    endfunction

    sched_state_t  state, state_n;
    logic [31:0]   addr, addr_n;
    logic [SW-1:0] sec_cnt, sec_n;
    logic [15:0]   fidx_n;
    logic [1:0]    slot_n;
    logic          tick_pend, tick_n;
    logic          err_n;
    logic          start_q, start_n;
    logic [31:0]   sec_addr_q, sec_addr_n;
    logic          fstart_n, fdone_n;
    logic          issue;
    logic          rise, fall, expired;

    sd_rd_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .busy_in (sd.rd_busy),
        .clear   (issue),
        .run     ((state == WAIT_BUSY) || (state == WAIT_DONE)),
        .rise    (rise),
        .fall    (fall),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            sec_cnt     <= '0;
            frame_idx   <= '0;
            cur_slot    <= '0;
            tick_pend   <= 1'b0;
            err_timeout <= 1'b0;
            start_q     <= 1'b0;
            sec_addr_q  <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            sec_cnt     <= sec_n;
            frame_idx   <= fidx_n;
            cur_slot    <= slot_n;
            tick_pend   <= tick_n;
            err_timeout <= err_n;
            start_q     <= start_n;
            sec_addr_q  <= sec_addr_n;
            frame_start <= fstart_n;
            frame_done  <= fdone_n;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        sec_n      = sec_cnt;
        fidx_n     = frame_idx;
        slot_n     = cur_slot;
        // Ticks arriving while one is already pending collapse into it.
        tick_n     = tick_pend | frame_tick;
        err_n      = err_timeout;
        start_n    = 1'b0;
        sec_addr_n = sec_addr_q;
        fstart_n   = 1'b0;
        fdone_n    = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    slot_n   = switch_video;
                    addr_n   = slot_base(switch_video);
                    fidx_n   = '0;
                    sec_n    = '0;
                    tick_n   = 1'b0;
                    fstart_n = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (!fifo_afull) begin
                    start_n    = 1'b1;
                    sec_addr_n = addr;
                    issue      = 1'b1;
                    state_n    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (rise) begin
                    state_n = WAIT_DONE;
                end else if (expired) begin
                    state_n = ERROR;
                end
            end
            WAIT_DONE: begin
                // Same timer as WAIT_BUSY: the limit covers the whole sector.
                if (fall) begin
                    state_n = NEXT;
                end else if (expired) begin
                    state_n = ERROR;
                end
            end
            NEXT: begin
                if (sec_cnt == SW'(FRAME_SECS - 1)) begin
                    fdone_n = 1'b1;
                    sec_n   = '0;
                    if (frame_idx == 16'(FRAMES_PER_CLIP - 1)) begin
                        fidx_n = '0;
                        addr_n = slot_base(cur_slot);
                    end else begin
                        fidx_n = frame_idx + 16'd1;
                        addr_n = addr + 32'd1;
                    end
                    state_n = FRAME_WAIT;
                end else begin
                    sec_n   = sec_cnt + 1'b1;
                    addr_n  = addr + 32'd1;
                    state_n = ISSUE;
                end
                if (!enable) begin
                    state_n = IDLE;
                end
            end
            FRAME_WAIT: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (tick_pend || !PACE_EN) begin
                    tick_n = 1'b0;
                    // Slot changes are only honoured here, between frames.
                    if (switch_video != cur_slot) begin
                        slot_n = switch_video;
                        addr_n = slot_base(switch_video);
                        fidx_n = '0;
                    end
                    fstart_n = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ERROR: begin
                err_n = 1'b1;
                if (!enable) begin
                    err_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sd.rd_start_en = start_q;
    assign sd.rd_sec_addr = sec_addr_q;
    assign busy           = (state != IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_sd_frame_read_sched.sv
module tb_sd_frame_read_sched;
    import sd_video_pkg::*;

    localparam int          FS  = 4;
    localparam int          FPC = 3;
    localparam int          TO  = 64;
    localparam logic [31:0] S0  = 32'd16640;
    localparam logic [31:0] S1  = 32'd2978816;
    localparam logic [31:0] S2  = 32'd5941248;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         enable = 1'b0;
    logic [1:0]   switch_video = 2'd0;
    logic         frame_tick = 1'b0;
    logic         fifo_afull = 1'b0;
    logic         frame_start, frame_done, err_timeout, busy;
    logic [1:0]   cur_slot;
    logic [15:0]  frame_idx;
    sched_state_t dbg_state;

    sd_frame_read_sched_if sd_bus ();

    sd_frame_read_sched #(
        .FRAME_SECS      (FS),
        .FRAMES_PER_CLIP (FPC),
        .TIMEOUT_CYC     (TO),
        .PACE_EN         (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .switch_video (switch_video),
        .frame_tick   (frame_tick),
        .fifo_afull   (fifo_afull),
        .sd           (sd_bus),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .cur_slot     (cur_slot),
        .frame_idx    (frame_idx),
        .err_timeout  (err_timeout),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_fstart = 0;
    int n_fdone = 0;
    bit model_on = 1'b1;

    // expected start: {slot, frame_idx, sector address}
    logic [49:0] exp_q[$];
    logic [49:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [1:0] slot, input logic [15:0] idx, input logic [31:0] base);
        for (int i = 0; i < FS; i++) begin
            exp_q.push_back({slot, idx, base + 32'(i)});
        end
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic wait_fdone(input int target, input int budget, input string name);
        int c = 0;
        while (n_fdone < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(n_fdone >= target), 32'd1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int c = 0;
        while (n_start < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(n_start >= target), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int c = 0;
        while (sd_bus.rd_busy !== lvl && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(sd_bus.rd_busy), 32'(lvl));
    endtask

    // SD controller model: busy 2 cycles after start, held for 10 cycles.
    initial begin
        sd_bus.rd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (sd_bus.rd_start_en && model_on && !rst) begin
                repeat (2) @(negedge clk);
                sd_bus.rd_busy = 1'b1;
                repeat (10) @(negedge clk);
                sd_bus.rd_busy = 1'b0;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start) n_fstart++;
            if (frame_done) n_fdone++;
            if (sd_bus.rd_start_en) begin
                n_start++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_start: got addr %0d expected no start", sd_bus.rd_sec_addr);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({cur_slot, frame_idx, sd_bus.rd_sec_addr} !== exp_e) begin
                        bad++;
                        $display("FAIL start: got slot=%0d idx=%0d addr=%0d expected slot=%0d idx=%0d addr=%0d",
                                 cur_slot, frame_idx, sd_bus.rd_sec_addr,
                                 exp_e[49:48], exp_e[47:32], exp_e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        int c;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_start_en", 32'(sd_bus.rd_start_en), 32'd0);
        check("rst_sec_addr", sd_bus.rd_sec_addr, 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_cur_slot", 32'(cur_slot), 32'd0);
        check("rst_frame_idx", 32'(frame_idx), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // basic frame from slot 0
        push_frame(2'd0, 16'd0, S0);
        enable = 1'b1;
        @(negedge clk);
        check("frame_start_pulse", 32'(frame_start), 32'd1);
        check("start_not_yet", 32'(sd_bus.rd_start_en), 32'd0);
        @(negedge clk);
        check("enable_to_start_2cyc", 32'(sd_bus.rd_start_en), 32'd1);
        wait_fdone(1, 300, "basic_frame_done");
        repeat (40) @(negedge clk);
        check("basic_starts", 32'(n_start), 32'd4);
        check("basic_q_empty", 32'(exp_q.size()), 32'd0);
        check("basic_frame_wait", 32'(dbg_state), 32'(FRAME_WAIT));

        // wrap through three frames; also busy fall -> next start latency
        push_frame(2'd0, 16'd1, S0 + 32'd4);
        push_frame(2'd0, 16'd2, S0 + 32'd8);
        push_frame(2'd0, 16'd0, S0);
        tick();
        wait_busy(1'b1, 50, "wrap_busy_high");
        c = 0;
        while (sd_bus.rd_busy && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        check("fall_latency_not_yet", 32'(sd_bus.rd_start_en), 32'd0);
        @(posedge clk); #1;
        check("fall_latency_3cyc", 32'(sd_bus.rd_start_en), 32'd1);
        wait_fdone(2, 300, "wrap_frame1_done");
        tick();
        wait_fdone(3, 300, "wrap_frame2_done");
        tick();
        wait_fdone(4, 300, "wrap_frame0_done");
        check("wrap_frame_starts", 32'(n_fstart), 32'd4);
        check("wrap_next_idx", 32'(frame_idx), 32'd1);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // slot switch mid-frame waits for the frame boundary
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("disable_idle", 32'(busy), 32'd0);
        push_frame(2'd0, 16'd0, S0);
        s0 = n_start;
        enable = 1'b1;
        wait_starts(s0 + 2, 100, "switch_sector1");
        switch_video = 2'd1;
        wait_fdone(5, 300, "switch_old_frame_done");
        check("switch_slot_held", 32'(cur_slot), 32'd0);
        push_frame(2'd1, 16'd0, S1);
        tick();
        wait_fdone(6, 300, "switch_new_frame_done");
        check("switch_cur_slot", 32'(cur_slot), 32'd1);
        check("switch_q_empty", 32'(exp_q.size()), 32'd0);

        // backpressure holds the start, same address afterwards
        fifo_afull = 1'b1;
        push_frame(2'd1, 16'd1, S1 + 32'd4);
        tick();
        s0 = n_start;
        repeat (20) @(negedge clk);
        check("afull_no_start", 32'(n_start), 32'(s0));
        check("afull_in_issue", 32'(dbg_state), 32'(ISSUE));
        fifo_afull = 1'b0;
        @(negedge clk);
        check("afull_release_start", 32'(sd_bus.rd_start_en), 32'd1);
        check("afull_release_addr", sd_bus.rd_sec_addr, S1 + 32'd4);
        wait_fdone(7, 300, "afull_frame_done");

        // enable drop while the sector is in flight
        exp_q.push_back({2'd1, 16'd2, S1 + 32'd8});
        tick();
        wait_busy(1'b1, 50, "drop_busy_high");
        enable = 1'b0;
        wait_busy(1'b0, 50, "drop_busy_low");
        repeat (5) @(negedge clk);
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_state", 32'(dbg_state), 32'(IDLE));
        s0 = n_start;
        repeat (20) @(negedge clk);
        check("drop_no_start", 32'(n_start), 32'(s0));
        check("drop_q_empty", 32'(exp_q.size()), 32'd0);

        // timeout: controller never raises busy
        model_on = 1'b0;
        switch_video = 2'd2;
        exp_q.push_back({2'd2, 16'd0, S2});
        s0 = n_start;
        enable = 1'b1;
        wait_starts(s0 + 1, 50, "to_first_start");
        c = 0;
        while (!err_timeout && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("to_err_set", 32'(err_timeout), 32'd1);
        check("to_cycles_in_range", 32'(c >= 62 && c <= 67), 32'd1);
        s0 = n_start;
        repeat (20) @(negedge clk);
        check("to_no_start", 32'(n_start), 32'(s0));
        check("to_state_error", 32'(dbg_state), 32'(ERROR));
        check("to_err_sticky", 32'(err_timeout), 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("to_err_cleared", 32'(err_timeout), 32'd0);
        check("to_idle", 32'(busy), 32'd0);

        // reset in the middle of a sector
        model_on = 1'b1;
        switch_video = 2'd0;
        exp_q.push_back({2'd0, 16'd0, S0});
        enable = 1'b1;
        wait_busy(1'b1, 50, "mrst_busy_high");
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_start_en", 32'(sd_bus.rd_start_en), 32'd0);
        check("mrst_sec_addr", sd_bus.rd_sec_addr, 32'd0);
        check("mrst_frame_idx", 32'(frame_idx), 32'd0);
        check("mrst_frame_start", 32'(frame_start), 32'd0);
        check("mrst_frame_done", 32'(frame_done), 32'd0);
        check("mrst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("mrst_stays_idle", 32'(busy), 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
